capture_readout: RTL and testbench



---
 rtl/capture_readout.sv | 106 ++++++++++
 tb/tb_capture_readout.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/capture_readout.sv
// capture_readout: streams a filled capture RAM to the UART as a framed dump
// (two header bytes, DEPTH payload bytes from address 0, XOR checksum of the payload).
module capture_readout #(
    parameter int          ADDR_W = 17,
    parameter int          DEPTH  = 131072,
    parameter logic [7:0]  HDR0   = 8'hA5,
    parameter logic [7:0]  HDR1   = 8'h5A
) (
    input  logic              clk_50M,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_en,
    input  logic [7:0]        rd_data,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              busy,
    output logic              done
);
    typedef enum logic [2:0] {S_IDLE, S_HDR0, S_HDR1, S_RD, S_WT, S_SEND, S_CSUM, S_FIN} state_t;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
    state_t            r_state;
    logic [ADDR_W-1:0] r_addr;
    logic              r_rd_en;
    logic [7:0]        r_data;
    logic              r_valid;
    logic              r_done;
    logic [7:0]        r_csum;
    logic              w_xfer;
    assign w_xfer   = r_valid && tx_ready;
    assign rd_addr  = r_addr;
    assign rd_en    = r_rd_en;
    assign tx_data  = r_data;
    assign tx_valid = r_valid;
    assign done     = r_done;
    assign busy     = r_state != S_IDLE;
    always_ff @(posedge clk_50M) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_rd_en <= 1'b0;
            r_data  <= 8'h00;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
            r_csum  <= 8'h00;
        end else if (abort && r_state != S_IDLE) begin
            // an abort drops the byte on offer even if it would transfer this cycle
            r_state <= S_IDLE;
            r_valid <= 1'b0;
            r_rd_en <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (start && !abort) begin
                    r_state <= S_HDR0;
                    r_addr  <= '0;
                    r_csum  <= 8'h00;
                    r_data  <= HDR0;
                    r_valid <= 1'b1;
                end
                S_HDR0: if (w_xfer) begin
                    r_state <= S_HDR1;
                    r_data  <= HDR1;
                end
                S_HDR1: if (w_xfer) begin
                    r_state <= S_RD;
                    r_valid <= 1'b0;
                    r_rd_en <= 1'b1;
                end
                S_RD: begin
                    r_state <= S_WT;
                    r_rd_en <= 1'b0;
                end
                S_WT: begin
                    r_state <= S_SEND;
                    r_data  <= rd_data;
                    r_csum  <= r_csum ^ rd_data;
                    r_valid <= 1'b1;
                end
                S_SEND: if (w_xfer) begin
                    if (r_addr == LAST) begin
                        r_state <= S_CSUM;
                        r_data  <= r_csum;
                    end else begin
                        r_state <= S_RD;
                        r_addr  <= r_addr + 1'b1;
                        r_valid <= 1'b0;
                        r_rd_en <= 1'b1;
                    end
                end
                S_CSUM: if (w_xfer) begin
                    r_state <= S_FIN;
                    r_valid <= 1'b0;
                    r_done  <= 1'b1;
                end
                S_FIN: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_capture_readout.sv
// tb_capture_readout: scoreboard bench for capture_readout (DEPTH=4 and full-range DEPTH=16 instances).
module tb_capture_readout;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       a_start, a_abort, a_ready, a_rd_en, a_valid, a_busy, a_done;
    logic [3:0] a_addr;
    logic [7:0] a_rdata, a_data;
    logic       b_start, b_abort, b_rd_en, b_valid, b_busy, b_done;
    logic       b_ready = 1'b1;
    logic [3:0] b_addr;
    logic [7:0] b_rdata, b_data;
    logic [7:0] mem_a [4];
    logic [7:0] mem_b [16];
    logic [7:0] qa [$];
    logic [7:0] qb [$];
    int checks = 0, errors = 0, cyc = 0, mode = 0, stall = 0;
    int a_rd_cnt = 0, a_dones = 0, a_last_x = 0, a_stall_seen = 0;
    int b_rd_cnt = 0, b_dones = 0, b_last_x = 0;
    logic       a_hold = 1'b0;
    logic [7:0] a_prev = 8'h00;
    always #10 clk = ~clk;
    capture_readout #(.ADDR_W(4), .DEPTH(4)) dut_a (
        .clk_50M(clk), .rst(rst), .start(a_start), .abort(a_abort),
        .rd_addr(a_addr), .rd_en(a_rd_en), .rd_data(a_rdata),
        .tx_data(a_data), .tx_valid(a_valid), .tx_ready(a_ready),
        .busy(a_busy), .done(a_done));
    capture_readout #(.ADDR_W(4), .DEPTH(16)) dut_b (
        .clk_50M(clk), .rst(rst), .start(b_start), .abort(b_abort),
        .rd_addr(b_addr), .rd_en(b_rd_en), .rd_data(b_rdata),
        .tx_data(b_data), .tx_valid(b_valid), .tx_ready(b_ready),
        .busy(b_busy), .done(b_done));
    always @(posedge clk) begin
        cyc++;
        if (a_rd_en) a_rdata <= mem_a[a_addr[1:0]];
        if (b_rd_en) b_rdata <= mem_b[b_addr];
    end
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    always @(negedge clk) begin
        if (!rst) begin
            if (a_rd_en) begin
                chk("a_rd_addr", a_addr, a_rd_cnt);
                a_rd_cnt++;
            end
            if (a_hold) begin
                chk("a_hold_valid", a_valid, 1);
                chk("a_hold_data", a_data, a_prev);
            end
            if (a_valid && !a_ready && a_data == 8'h22) a_stall_seen++;
            if (a_valid && a_ready && !a_abort) begin
                chk("a_q_nonempty", qa.size() != 0, 1);
                if (qa.size() != 0) chk("a_byte", a_data, qa.pop_front());
                a_last_x = cyc;
            end
            if (a_done) begin
                a_dones++;
                chk("a_done_lat", cyc - a_last_x, 1);
                chk("a_done_q", qa.size(), 0);
                chk("a_done_busy", a_busy, 1);
            end
            if (b_rd_en) begin
                chk("b_rd_addr", b_addr, b_rd_cnt);
                b_rd_cnt++;
            end
            if (b_valid && b_ready && !b_abort) begin
                chk("b_q_nonempty", qb.size() != 0, 1);
                if (qb.size() != 0) chk("b_byte", b_data, qb.pop_front());
                b_last_x = cyc;
            end
            if (b_done) begin
                b_dones++;
                chk("b_done_lat", cyc - b_last_x, 1);
            end
        end
        a_hold = a_valid && !a_ready && !a_abort && !rst;
        a_prev = a_data;
    end
    initial begin
        a_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (mode)
                0: a_ready = 1'b1;
                1: a_ready = ~a_ready;
                default: begin
                    if (a_valid && a_data == 8'h22 && stall < 20) begin
                        a_ready = 1'b0;
                        stall++;
                    end else a_ready = 1'b1;
                end
            endcase
        end
    end
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic push_frame_a();
        logic [7:0] x = 8'h00;
        qa.push_back(8'hA5);
        qa.push_back(8'h5A);
        foreach (mem_a[i]) begin
            qa.push_back(mem_a[i]);
            x ^= mem_a[i];
        end
        qa.push_back(x);
    endtask
    task automatic start_a();
        a_rd_cnt = 0;
        a_start = 1'b1;
        step(1);
        a_start = 1'b0;
        chk("a_valid_rise", a_valid, 1);
        chk("a_busy_rise", a_busy, 1);
    endtask
    task automatic wait_done_a();
        int n = 0;
        while (!a_done && n < 2000) begin
            step(1);
            n++;
        end
        chk("a_done_seen", a_done, 1);
        step(1);
        chk("a_busy_fall", a_busy, 0);
        chk("a_done_fall", a_done, 0);
    endtask
    task automatic wait_byte_a(input logic [7:0] v);
        int n = 0;
        while (!(a_valid && a_data == v) && n < 200) begin
            step(1);
            n++;
        end
        chk("a_byte_seen", a_valid && a_data == v, 1);
    endtask
    task automatic check_reset_a(input string tag);
        chk({tag, "_addr"}, a_addr, 0);
        chk({tag, "_rd_en"}, a_rd_en, 0);
        chk({tag, "_data"}, a_data, 0);
        chk({tag, "_valid"}, a_valid, 0);
        chk({tag, "_busy"}, a_busy, 0);
        chk({tag, "_done"}, a_done, 0);
    endtask
    initial begin
        int d0, n;
        logic [7:0] xb;
        a_start = 0; a_abort = 0; b_start = 0; b_abort = 0;
        foreach (mem_b[i]) mem_b[i] = 8'(i);
        step(3);
        check_reset_a("rst");
        chk("rst_b_valid", b_valid, 0);
        rst = 1'b0;
        step(2);
        // plain frame, ready tied high
        mem_a = '{8'h11, 8'h22, 8'h33, 8'h44};
        push_frame_a();
        start_a();
        wait_done_a();
        chk("t1_q", qa.size(), 0);
        chk("t1_rd", a_rd_cnt, 4);
        chk("t1_dones", a_dones, 1);
        // ready toggling every cycle
        mode = 1;
        mem_a = '{8'h01, 8'h02, 8'h04, 8'h80};
        push_frame_a();
        start_a();
        wait_done_a();
        chk("t2_q", qa.size(), 0);
        chk("t2_rd", a_rd_cnt, 4);
        // 20-cycle stall on the second payload byte
        mode = 2;
        stall = 0;
        a_stall_seen = 0;
        mem_a = '{8'h11, 8'h22, 8'h33, 8'h44};
        push_frame_a();
        start_a();
        wait_done_a();
        chk("t3_q", qa.size(), 0);
        chk("t3_stall", a_stall_seen, 20);
        chk("t3_rd", a_rd_cnt, 4);
        chk("t3_addr", a_addr, 3);
        // abort while the third payload byte is on offer with ready high
        mode = 0;
        step(1);
        mem_a = '{8'h01, 8'h02, 8'h04, 8'h80};
        qa.push_back(8'hA5); qa.push_back(8'h5A); qa.push_back(8'h01); qa.push_back(8'h02);
        d0 = a_dones;
        start_a();
        wait_byte_a(8'h04);
        a_abort = 1'b1;
        step(1);
        a_abort = 1'b0;
        chk("t4_busy", a_busy, 0);
        chk("t4_valid", a_valid, 0);
        chk("t4_rd_en", a_rd_en, 0);
        step(2);
        chk("t4_no_done", a_dones, d0);
        chk("t4_q", qa.size(), 0);
        push_frame_a();
        start_a();
        wait_done_a();
        chk("t4_refr_q", qa.size(), 0);
        // abort wins over start in IDLE
        a_start = 1'b1; a_abort = 1'b1;
        step(1);
        chk("idle_abort_busy", a_busy, 0);
        a_start = 1'b0; a_abort = 1'b0;
        step(1);
        chk("idle_abort_busy2", a_busy, 0);
        // reset mid-payload
        mem_a = '{8'h11, 8'h22, 8'h33, 8'h44};
        push_frame_a();
        start_a();
        wait_byte_a(8'h22);
        rst = 1'b1;
        step(1);
        check_reset_a("mid_rst");
        step(1);
        chk("mid_rst_valid2", a_valid, 0);
        qa.delete();
        rst = 1'b0;
        step(1);
        mem_a = '{8'h10, 8'h20, 8'h30, 8'h07};
        push_frame_a();
        start_a();
        wait_done_a();
        chk("t5_q", qa.size(), 0);
        chk("t5_rd", a_rd_cnt, 4);
        // full address range, DEPTH = 2^ADDR_W
        xb = 8'h00;
        qb.push_back(8'hA5); qb.push_back(8'h5A);
        foreach (mem_b[i]) begin
            qb.push_back(mem_b[i]);
            xb ^= mem_b[i];
        end
        qb.push_back(xb);
        b_rd_cnt = 0;
        b_start = 1'b1;
        step(1);
        b_start = 1'b0;
        n = 0;
        while (!b_done && n < 2000) begin
            step(1);
            n++;
        end
        chk("b_done_seen", b_done, 1);
        chk("b_addr_final", b_addr, 4'hF);
        step(1);
        chk("b_busy_fall", b_busy, 0);
        chk("b_q", qb.size(), 0);
        chk("b_rd", b_rd_cnt, 16);
        chk("b_dones", b_dones, 1);
        chk("b_addr_hold", b_addr, 4'hF);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end
endmodule
